// File: rtl/sik_stack_file_if.sv
// Execute-stage <-> operand-stack-store port bundle: one op in, one registered response out.
interface sik_stack_file_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned PTRW    = 8,
    parameter int unsigned TIDW    = 1,
    parameter int unsigned THREADS = 2
);
    logic                  op_valid;
    logic [TIDW-1:0]       op_tid;
    logic [2:0]            op_code;
    logic [WIDTH-1:0]      op_din;
    logic [PTRW-1:0]       op_off;
    logic [THREADS-1:0]    fault_clr;

    logic                  rsp_valid;
    logic [TIDW-1:0]       rsp_tid;
    logic [WIDTH-1:0]      rsp_tos;
    logic [WIDTH-1:0]      rsp_nos;
    logic [PTRW:0]         rsp_cnt;
    logic [1:0]            rsp_err;
    logic [THREADS-1:0]    fault;

    modport master (
        output op_valid, op_tid, op_code, op_din, op_off, fault_clr,
        input  rsp_valid, rsp_tid, rsp_tos, rsp_nos, rsp_cnt, rsp_err, fault
    );

    modport slave (
        input  op_valid, op_tid, op_code, op_din, op_off, fault_clr,
        output rsp_valid, rsp_tid, rsp_tos, rsp_nos, rsp_cnt, rsp_err, fault
    );
endinterface

// File: rtl/sik_stack_file.sv
// Multithreaded operand-stack store: THREADS stacks of DEPTH words, one op per
// cycle, registered TOS/NOS/count/error response and sticky per-thread faults.
module sik_stack_file #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned THREADS = 2,
    parameter int unsigned PTRW    = $clog2(DEPTH),
    parameter int unsigned TIDW    = (THREADS > 1) ? $clog2(THREADS) : 1
) (
    input  logic           clk,
    input  logic           reset,
    sik_stack_file_if.slave bus
);
    localparam int unsigned CW = PTRW + 1;

    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_BINOP = 3'd3;
    localparam logic [2:0] OP_GET   = 3'd4;
    localparam logic [2:0] OP_PUT   = 3'd5;
    localparam logic [2:0] OP_REPL  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_OVF = 2'b01;
    localparam logic [1:0] ERR_UNF = 2'b10;
    localparam logic [1:0] ERR_BAD = 2'b11;

    logic [WIDTH-1:0]   mem_q   [THREADS][DEPTH];
    logic [CW-1:0]      cnt_q   [THREADS];
    logic [CW-1:0]      cnt_d   [THREADS];
    logic [1:0]         code_q  [THREADS];
    logic [1:0]         code_d  [THREADS];
    logic [THREADS-1:0] fault_q, fault_d;

    logic               rsp_valid_q, rsp_valid_d;
    logic [TIDW-1:0]    rsp_tid_q,   rsp_tid_d;
    logic [WIDTH-1:0]   rsp_tos_q,   rsp_tos_d;
    logic [WIDTH-1:0]   rsp_nos_q,   rsp_nos_d;
    logic [CW-1:0]      rsp_cnt_q,   rsp_cnt_d;
    logic [1:0]         rsp_err_q,   rsp_err_d;

    logic               tid_ok;
    logic [TIDW-1:0]    tid;
    logic [CW-1:0]      cnt;
    logic               flt;
    logic               off_ok;
    logic [PTRW-1:0]    top_idx, src_idx;

    logic [1:0]         op_err;
    logic [CW-1:0]      op_cnt;
    logic               op_we;
    logic [PTRW-1:0]    op_waddr;
    logic [WIDTH-1:0]   op_wdata;

    logic               mem_we;
    logic [CW-1:0]      res_cnt;
    logic [1:0]         res_err;
    logic [PTRW-1:0]    tos_idx, nos_idx;
    logic [WIDTH-1:0]   tos_val, nos_val;

    assign tid_ok  = bus.op_valid && (32'(bus.op_tid) < THREADS);
    assign tid     = tid_ok ? bus.op_tid : '0;
    assign cnt     = cnt_q[tid];
    // A clear landing with the op un-faults the thread before the op runs.
    assign flt     = fault_q[tid] && !bus.fault_clr[tid];
    assign off_ok  = CW'(bus.op_off) < cnt;
    assign top_idx = PTRW'(cnt - CW'(1));
    assign src_idx = PTRW'(cnt - CW'(1) - CW'(bus.op_off));

    // Per-op legality, new count and the single storage write it implies.
    always_comb begin
        op_err   = ERR_OK;
        op_cnt   = cnt;
        op_we    = 1'b0;
        op_waddr = top_idx;
        op_wdata = bus.op_din;
        case (bus.op_code)
            OP_PUSH: begin
                if (cnt == CW'(DEPTH)) op_err = ERR_OVF;
                else begin
                    op_we    = 1'b1;
                    op_waddr = PTRW'(cnt);
                    op_cnt   = cnt + CW'(1);
                end
            end
            OP_POP: begin
                if (cnt == '0) op_err = ERR_UNF;
                else           op_cnt = cnt - CW'(1);
            end
            OP_BINOP: begin
                if (cnt < CW'(2)) op_err = ERR_UNF;
                else begin
                    op_we    = 1'b1;
                    op_waddr = PTRW'(cnt - CW'(2));
                    op_cnt   = cnt - CW'(1);
                end
            end
            OP_GET: begin
                if (!off_ok)                op_err = ERR_BAD;
                else if (cnt == CW'(DEPTH)) op_err = ERR_OVF;
                else begin
                    op_we    = 1'b1;
                    op_waddr = PTRW'(cnt);
                    op_wdata = mem_q[tid][src_idx];
                    op_cnt   = cnt + CW'(1);
                end
            end
            OP_PUT: begin
                if (!off_ok) op_err = ERR_BAD;
                else begin
                    op_we    = 1'b1;
                    op_waddr = src_idx;
                    op_wdata = mem_q[tid][top_idx];
                    op_cnt   = cnt - CW'(1);
                end
            end
            OP_REPL: begin
                if (cnt == '0) op_err = ERR_UNF;
                else           op_we  = 1'b1;
            end
            OP_CLEAR: op_cnt = '0;
            default: ;
        endcase
    end

    // Commit/fault decision and response build; TOS/NOS bypass this op's write.
    always_comb begin
        cnt_d       = cnt_q;
        code_d      = code_q;
        fault_d     = fault_q & ~bus.fault_clr;
        rsp_valid_d = 1'b0;
        rsp_tid_d   = rsp_tid_q;
        rsp_tos_d   = rsp_tos_q;
        rsp_nos_d   = rsp_nos_q;
        rsp_cnt_d   = rsp_cnt_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        res_cnt     = cnt;
        res_err     = ERR_OK;
        for (int t = 0; t < THREADS; t++) begin
            if (bus.fault_clr[t]) code_d[t] = ERR_OK;
        end
        if (tid_ok) begin
            if (flt) begin
                res_err = code_q[tid];
            end else if (op_err != ERR_OK) begin
                res_err      = op_err;
                fault_d[tid] = 1'b1;
                code_d[tid]  = op_err;
            end else begin
                res_cnt    = op_cnt;
                cnt_d[tid] = op_cnt;
                mem_we     = op_we;
            end
        end
        tos_idx = PTRW'(res_cnt - CW'(1));
        nos_idx = PTRW'(res_cnt - CW'(2));
        tos_val = (mem_we && op_waddr == tos_idx) ? op_wdata : mem_q[tid][tos_idx];
        nos_val = (mem_we && op_waddr == nos_idx) ? op_wdata : mem_q[tid][nos_idx];
        if (tid_ok) begin
            rsp_valid_d = 1'b1;
            rsp_tid_d   = tid;
            rsp_cnt_d   = res_cnt;
            rsp_err_d   = res_err;
            rsp_tos_d   = (res_cnt >= CW'(1)) ? tos_val : '0;
            rsp_nos_d   = (res_cnt >= CW'(2)) ? nos_val : '0;
        end
    end

    // Stack storage is deliberately unreset; unoccupied entries are never shown.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[tid][op_waddr] <= op_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < THREADS; t++) begin
                cnt_q[t]  <= '0;
                code_q[t] <= ERR_OK;
            end
            fault_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_tos_q   <= '0;
            rsp_nos_q   <= '0;
            rsp_cnt_q   <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            fault_q     <= fault_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_tos_q   <= rsp_tos_d;
            rsp_nos_q   <= rsp_nos_d;
            rsp_cnt_q   <= rsp_cnt_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_tid   = rsp_tid_q;
    assign bus.rsp_tos   = rsp_tos_q;
    assign bus.rsp_nos   = rsp_nos_q;
    assign bus.rsp_cnt   = rsp_cnt_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.fault     = fault_q;
endmodule

// File: tb/tb_sik_stack_file.sv
// Directed bench for sik_stack_file (DEPTH=4, two threads) with an expectation queue.
module tb_sik_stack_file;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned THREADS = 2;
    localparam int unsigned PTRW    = 2;
    localparam int unsigned TIDW    = 1;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, BIN = 3'd3;
    localparam logic [2:0] GET = 3'd4, PUT = 3'd5, REPL = 3'd6, CLR = 3'd7;

    typedef struct {
        int          step;
        logic        v;
        logic [15:0] tid;
        logic [15:0] tos;
        logic [15:0] nos;
        logic [15:0] cnt;
        logic [15:0] err;
        logic [15:0] flt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    always #5 clk = ~clk;

    sik_stack_file_if #(.WIDTH(WIDTH), .PTRW(PTRW), .TIDW(TIDW), .THREADS(THREADS)) bus ();

    sik_stack_file #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .THREADS(THREADS), .PTRW(PTRW), .TIDW(TIDW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input int step, input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL step%0d %s got %h expected %h", step, tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the response it must produce.
    task automatic op(input logic v, input int tid, input logic [2:0] code, input logic [15:0] din,
                      input logic [1:0] off, input logic [1:0] clr,
                      input logic [15:0] etos, input logic [15:0] enos, input logic [2:0] ecnt,
                      input logic [1:0] eerr, input logic [1:0] eflt);
        exp_t x;
        @(negedge clk);
        step_no++;
        bus.op_valid  = v;
        bus.op_tid    = TIDW'(tid);
        bus.op_code   = code;
        bus.op_din    = din;
        bus.op_off    = off;
        bus.fault_clr = clr;
        x.step = step_no; x.v = v; x.tid = 16'(tid);
        x.tos = etos; x.nos = enos; x.cnt = 16'(ecnt); x.err = 16'(eerr); x.flt = 16'(eflt);
        sb.push_back(x);
    endtask

    // Response checker: one cycle after the sampling edge.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.step, "valid", 16'(bus.rsp_valid), 16'(e.v));
            chk(e.step, "tid",   16'(bus.rsp_tid),   e.tid);
            chk(e.step, "tos",   bus.rsp_tos,        e.tos);
            chk(e.step, "nos",   bus.rsp_nos,        e.nos);
            chk(e.step, "cnt",   16'(bus.rsp_cnt),   e.cnt);
            chk(e.step, "err",   16'(bus.rsp_err),   e.err);
            chk(e.step, "fault", 16'(bus.fault),     e.flt);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        bus.op_valid  = 1'b0;
        bus.op_tid    = '0;
        bus.op_code   = NOP;
        bus.op_din    = '0;
        bus.op_off    = '0;
        bus.fault_clr = '0;
        repeat (2) @(negedge clk);
        chk(0, "rst_valid", 16'(bus.rsp_valid), 16'h0);
        chk(0, "rst_cnt",   16'(bus.rsp_cnt),   16'h0);
        chk(0, "rst_tos",   bus.rsp_tos,        16'h0);
        chk(0, "rst_fault", 16'(bus.fault),     16'h0);
        reset = 1'b1;

        // Async reset in the middle of traffic
        op(1, 0, PUSH, 16'h0001, 0, 0, 16'h0001, 16'h0000, 1, 0, 0);
        op(1, 0, PUSH, 16'h0002, 0, 0, 16'h0002, 16'h0001, 2, 0, 0);
        op(1, 0, PUSH, 16'h0003, 0, 0, 16'h0003, 16'h0002, 3, 0, 0);
        @(negedge clk);
        bus.op_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk(100, "rst2_valid", 16'(bus.rsp_valid), 16'h0);
        chk(100, "rst2_cnt",   16'(bus.rsp_cnt),   16'h0);
        @(posedge clk);
        #1;
        chk(101, "rst2_valid_next", 16'(bus.rsp_valid), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        op(1, 0, NOP, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);

        // Interleaved threads
        op(1, 0, PUSH, 16'h1111, 0, 0, 16'h1111, 16'h0000, 1, 0, 0);
        op(1, 1, PUSH, 16'hAAAA, 0, 0, 16'hAAAA, 16'h0000, 1, 0, 0);
        op(1, 0, PUSH, 16'h2222, 0, 0, 16'h2222, 16'h1111, 2, 0, 0);

        // Overflow, fault isolation, faulted op, clear-with-op
        op(1, 0, PUSH, 16'h3333, 0, 0, 16'h3333, 16'h2222, 3, 0, 0);
        op(1, 0, PUSH, 16'h4444, 0, 0, 16'h4444, 16'h3333, 4, 0, 0);
        op(1, 0, PUSH, 16'h5555, 0, 0, 16'h4444, 16'h3333, 4, 2'b01, 2'b01);
        op(1, 1, PUSH, 16'hBBBB, 0, 0, 16'hBBBB, 16'hAAAA, 2, 0, 2'b01);
        op(1, 0, POP,  16'h0,    0, 0, 16'h4444, 16'h3333, 4, 2'b01, 2'b01);
        op(1, 0, POP,  16'h0,    0, 2'b01, 16'h3333, 16'h2222, 3, 0, 0);

        // GET / PUT / bad offset
        op(1, 0, CLR,  16'h0,    0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        op(1, 0, PUSH, 16'h0010, 0, 0, 16'h0010, 16'h0000, 1, 0, 0);
        op(1, 0, PUSH, 16'h0020, 0, 0, 16'h0020, 16'h0010, 2, 0, 0);
        op(1, 0, GET,  16'h0,    1, 0, 16'h0010, 16'h0020, 3, 0, 0);
        op(1, 0, PUT,  16'h0,    2, 0, 16'h0020, 16'h0010, 2, 0, 0);
        op(1, 0, GET,  16'h0,    3, 0, 16'h0020, 16'h0010, 2, 2'b11, 2'b01);
        op(1, 0, NOP,  16'h0,    0, 2'b01, 16'h0020, 16'h0010, 2, 0, 0);
        op(1, 0, POP,  16'h0,    0, 0, 16'h0010, 16'h0000, 1, 0, 0);

        // BINOP underflow, CLEAR ignored while faulted, legal BINOP
        op(1, 0, BIN,  16'h0099, 0, 0, 16'h0010, 16'h0000, 1, 2'b10, 2'b01);
        op(1, 0, CLR,  16'h0,    0, 0, 16'h0010, 16'h0000, 1, 2'b10, 2'b01);
        op(1, 0, PUSH, 16'h0077, 0, 2'b01, 16'h0077, 16'h0010, 2, 0, 0);
        op(1, 0, BIN,  16'h0030, 0, 0, 16'h0030, 16'h0000, 1, 0, 0);

        // Back-to-back dependent ops, then an idle cycle that holds fields
        op(1, 0, CLR,  16'h0,    0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        op(1, 0, PUSH, 16'h0005, 0, 0, 16'h0005, 16'h0000, 1, 0, 0);
        op(1, 0, REPL, 16'h0007, 0, 0, 16'h0007, 16'h0000, 1, 0, 0);
        op(1, 0, GET,  16'h0,    0, 0, 16'h0007, 16'h0007, 2, 0, 0);
        op(1, 0, POP,  16'h0,    0, 0, 16'h0007, 16'h0000, 1, 0, 0);
        op(0, 0, NOP,  16'h0,    0, 0, 16'h0007, 16'h0000, 1, 0, 0);

        // Thread 1 drains to empty and underflows
        op(1, 1, PUT,  16'h0,    0, 0, 16'hAAAA, 16'h0000, 1, 0, 0);
        op(1, 1, POP,  16'h0,    0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        op(1, 1, POP,  16'h0,    0, 0, 16'h0000, 16'h0000, 0, 2'b10, 2'b10);

        @(negedge clk);
        bus.op_valid  = 1'b0;
        bus.fault_clr = '0;
        repeat (3) @(negedge clk);
        chk(999, "drain", 16'(sb.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
